if_stage: RTL



---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2,
    S_IDLE = 2'd3
  } fs_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // {adef, pc, inst} as packed by decode
  localparam int unsigned FS_TO_DS_BUS_WD = 65;

  function automatic logic misal(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: redirect, instruction SRAM and fetch-to-decode handshake.
interface if_stage_if;

  logic        br_valid;
  logic [31:0] br_target;
  logic        ds_allowin;

  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  modport master (
    input  br_valid, br_target, ds_allowin, inst_sram_rdata,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output fs_valid, fs_pc, fs_inst, fs_adef
  );

  modport slave (
    output br_valid, br_target, ds_allowin, inst_sram_rdata,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  fs_valid, fs_pc, fs_inst, fs_adef
  );

endinterface

// File: rtl/if_stage.sv
// Multi-cycle instruction-fetch stage: owns the PC, drives the one-cycle-latency
// instruction SRAM and presents {pc, inst, adef} to decode over valid/allowin.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        fs_adef_q, fs_adef_d;
  logic        fs_valid_q, fs_valid_d;
  logic        fire;
  logic        sram_en;
  logic [31:0] sram_addr;

  assign fire = fs_valid_q & bus.ds_allowin;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    fs_adef_d  = fs_adef_q;
    fs_valid_d = fs_valid_q;
    sram_en    = 1'b0;
    sram_addr  = 32'h0;

    if (reset) begin
      sram_en   = 1'b0;
      sram_addr = 32'h0;
    end else if (bus.br_valid) begin
      // Redirect wins over everything, including a same-cycle handoff.
      pc_d = bus.br_target;
      if (misal(bus.br_target)) begin
        state_d    = S_HOLD;
        fs_adef_d  = 1'b1;
        inst_buf_d = 32'h0;
        fs_valid_d = 1'b1;
      end else begin
        sram_en    = 1'b1;
        sram_addr  = bus.br_target;
        state_d    = S_RESP;
        fs_adef_d  = 1'b0;
        fs_valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          sram_en   = 1'b1;
          sram_addr = pc_q;
          state_d   = S_RESP;
        end
        S_RESP: begin
          inst_buf_d = bus.inst_sram_rdata;
          fs_adef_d  = 1'b0;
          fs_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (fire && !fs_adef_q) begin
            sram_en    = 1'b1;
            sram_addr  = pc_q + 32'd4;
            pc_d       = pc_q + 32'd4;
            fs_valid_d = 1'b0;
            state_d    = S_RESP;
          end else if (fire) begin
            // Misaligned fetch handed over; park until someone redirects us.
            fs_valid_d = 1'b0;
            fs_adef_d  = 1'b0;
            state_d    = S_IDLE;
          end
        end
        S_IDLE: begin
          fs_valid_d = 1'b0;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_buf_q <= 32'h0;
      fs_adef_q  <= 1'b0;
      fs_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      fs_adef_q  <= fs_adef_d;
      fs_valid_q <= fs_valid_d;
    end
  end

  assign bus.inst_sram_en    = sram_en;
  assign bus.inst_sram_addr  = sram_addr;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.fs_valid        = fs_valid_q;
  assign bus.fs_pc           = pc_q;
  assign bus.fs_inst         = inst_buf_q;
  assign bus.fs_adef         = fs_adef_q;

endmodule
